// File: rtl/clint_multi.sv
// rtl/clint_multi.sv - multi-hart core-local interruptor with prescaled shared mtime
// Ports:
//   clk, resetb               clock, asynchronous active-low reset
//   timer_en                  global mtime count enable
//   wready/waddr/wdata/wstrb  write request, byte enables honoured (wvalid tied 1)
//   rready/raddr              read request (rvalid tied 1)
//   rresp/rdata               registered read response, one cycle after rready
//   timer_irq, sw_irq         per-hart timer / software interrupts
//   ex_irq                    self-test external interrupt (MSIP[0] bit 16)
module clint_multi #(
  parameter logic [31:0] BASE       = 32'h0200_0000,
  parameter int          NHART      = 1,
  parameter int          PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             timer_en,
  input  logic             wready,
  output logic             wvalid,
  input  logic [31:0]      waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             rready,
  output logic             rvalid,
  input  logic [31:0]      raddr,
  output logic             rresp,
  output logic [31:0]      rdata,
  output logic [NHART-1:0] timer_irq,
  output logic [NHART-1:0] sw_irq,
  output logic             ex_irq
);

  // Word indices (byte offset >> 2) within the 64 KiB window
  localparam logic [13:0] IDX_CMP      = 14'h1000;
  localparam logic [13:0] IDX_PRESCALE = 14'h2FFC;
  localparam logic [13:0] IDX_MTIME_LO = 14'h2FFE;
  localparam logic [13:0] IDX_MTIME_HI = 14'h2FFF;

  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp [NHART];
  logic [31:0]           snap_hi;
  logic [31:0]           rmux;

  assign wvalid = 1'b1;
  assign rvalid = 1'b1;

  // Word-granular decode; anything below BASE wraps to a large offset and misses
  logic [29:0] wofs, rofs;
  logic        w_in, r_in;
  logic [13:0] widx, ridx;
  assign wofs = waddr[31:2] - BASE[31:2];
  assign rofs = raddr[31:2] - BASE[31:2];
  assign w_in = wready && (wofs[29:14] == '0);
  assign r_in = (rofs[29:14] == '0);
  assign widx = wofs[13:0];
  assign ridx = rofs[13:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr[1:0], raddr[1:0]};

  logic w_pre, w_mlo, w_mhi, r_mlo, tick;
  assign w_pre = w_in && (widx == IDX_PRESCALE);
  assign w_mlo = w_in && (widx == IDX_MTIME_LO);
  assign w_mhi = w_in && (widx == IDX_MTIME_HI);
  assign r_mlo = rready && r_in && (ridx == IDX_MTIME_LO);
  assign tick  = timer_en && (pcnt == prescale);

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    rmux = '0;
    if (r_in) begin
      for (int h = 0; h < NHART; h++) begin
        if (ridx == 14'(h)) begin
          rmux = 32'(sw_irq[h]);
          if (h == 0) rmux[16] = ex_irq;
        end
        if (ridx == IDX_CMP + 14'(2*h))         rmux = mtimecmp[h][31:0];
        if (ridx == IDX_CMP + 14'(2*h) + 14'd1) rmux = mtimecmp[h][63:32];
      end
      if (ridx == IDX_PRESCALE) rmux = 32'(prescale);
      if (ridx == IDX_MTIME_LO) rmux = mtime[31:0];
      // High half always comes from the snapshot taken by the last low read
      if (ridx == IDX_MTIME_HI) rmux = snap_hi;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      prescale  <= '0;
      pcnt      <= '0;
      mtime     <= '0;
      snap_hi   <= '0;
      sw_irq    <= '0;
      ex_irq    <= 1'b0;
      timer_irq <= '0;
      rresp     <= 1'b0;
      rdata     <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp[h] <= '1;
    end else begin
      if (w_pre) begin
        prescale <= PRESCALE_W'(merge(32'(prescale), wdata, wstrb));
        pcnt     <= '0;
      end else if (timer_en) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
      end

      // A software write to either half suppresses that cycle's increment
      if (w_mlo)      mtime[31:0]  <= merge(mtime[31:0], wdata, wstrb);
      else if (w_mhi) mtime[63:32] <= merge(mtime[63:32], wdata, wstrb);
      else if (tick)  mtime        <= mtime + 64'd1;

      if (w_in && (widx == 14'd0) && wstrb[2]) ex_irq <= wdata[16];

      for (int h = 0; h < NHART; h++) begin
        if (w_in && (widx == 14'(h)) && wstrb[0]) sw_irq[h] <= wdata[0];
        if (w_in && (widx == IDX_CMP + 14'(2*h)))
          mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], wdata, wstrb);
        if (w_in && (widx == IDX_CMP + 14'(2*h) + 14'd1))
          mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wdata, wstrb);
        timer_irq[h] <= (mtime >= mtimecmp[h]);
      end

      rresp <= rready;
      if (rready) rdata <= rmux;
      if (r_mlo)  snap_hi <= mtime[63:32];
    end
  end

endmodule

// File: tb/tb_clint_multi.sv
// tb/tb_clint_multi.sv - scoreboard bench for clint_multi with two harts
module tb_clint_multi;

  localparam logic [31:0] A_MSIP0 = 32'h0200_0000;
  localparam logic [31:0] A_MSIP1 = 32'h0200_0004;
  localparam logic [31:0] A_MSIP2 = 32'h0200_0008;
  localparam logic [31:0] A_CMP0L = 32'h0200_4000;
  localparam logic [31:0] A_CMP1L = 32'h0200_4008;
  localparam logic [31:0] A_CMP1H = 32'h0200_400C;
  localparam logic [31:0] A_PRE   = 32'h0200_BFF0;
  localparam logic [31:0] A_MLO   = 32'h0200_BFF8;
  localparam logic [31:0] A_MHI   = 32'h0200_BFFC;
  localparam logic [31:0] A_HOLE  = 32'h0200_8000;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        timer_en = 1'b0;
  logic        wready = 1'b0;
  logic        wvalid;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rready = 1'b0;
  logic        rvalid;
  logic [31:0] raddr = '0;
  logic        rresp;
  logic [31:0] rdata;
  logic [1:0]  timer_irq;
  logic [1:0]  sw_irq;
  logic        ex_irq;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  clint_multi #(.BASE(32'h0200_0000), .NHART(2), .PRESCALE_W(8)) dut (
    .clk(clk), .resetb(resetb), .timer_en(timer_en),
    .wready(wready), .wvalid(wvalid), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .rready(rready), .rvalid(rvalid), .raddr(raddr), .rresp(rresp), .rdata(rdata),
    .timer_irq(timer_irq), .sw_irq(sw_irq), .ex_irq(ex_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Response monitor: every rresp pops one expected read from the scoreboard
  always @(negedge clk) begin
    if (resetb && rresp) begin
      if (exp_q.size() == 0) chk("unexpected_rresp", 64'(rresp), 64'd0);
      else chk(tag_q.pop_front(), 64'(rdata), 64'(exp_q.pop_front()));
    end
  end

  // One bus cycle; caller is positioned #1 after a rising edge
  task automatic xfer(input bit dw, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input bit dr, input logic [31:0] ra,
                      input logic [31:0] expv, input string tag);
    wready = dw; waddr = wa; wdata = wd; wstrb = ws;
    rready = dr; raddr = ra;
    if (dr) begin
      exp_q.push_back(expv);
      tag_q.push_back(tag);
    end
    @(posedge clk); #1;
    wready = 1'b0; rready = 1'b0;
    if (dr) chk({tag, "_rresp"}, 64'(rresp), 64'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, a, d, s, 1'b0, '0, '0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv, input string tag);
    xfer(1'b0, '0, '0, '0, 1'b1, a, expv, tag);
  endtask

  task automatic run_en(input int n);
    timer_en = 1'b1;
    repeat (n) @(posedge clk);
    #1 timer_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
    chk("rst_timer_irq", 64'(timer_irq), 64'd0);
    chk("rst_sw_irq", 64'(sw_irq), 64'd0);
    chk("rst_ex_irq", 64'(ex_irq), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rd(A_CMP1H, 32'hFFFF_FFFF, "rst_cmp1_hi");

    // Prescaler: divide by 4, 40 enabled cycles -> 10 ticks
    wr(A_PRE, 32'd3, 4'hF);
    run_en(40);
    rd(A_MLO, 32'd10, "presc_mtime_lo");
    rd(A_MHI, 32'd0, "presc_mtime_hi");
    run_en(2);
    repeat (5) @(posedge clk);
    #1;
    rd(A_MLO, 32'd10, "en_off_hold");
    run_en(2);
    rd(A_MLO, 32'd11, "pcnt_held");

    // Carry into the high word and snapshot coherence
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_MLO, 32'hFFFF_FFFE, 4'hF);
    wr(A_MHI, 32'd0, 4'hF);
    run_en(2);
    rd(A_MLO, 32'd0, "carry_lo");
    xfer(1'b1, A_MHI, 32'h55, 4'hF, 1'b1, A_MHI, 32'd1, "carry_snap_hi");
    rd(A_MLO, 32'd0, "after_wr_lo");
    rd(A_MHI, 32'h55, "after_wr_hi");

    // Timer compare on hart 1
    wr(A_MLO, 32'd0, 4'hF);
    wr(A_MHI, 32'd0, 4'hF);
    wr(A_CMP1L, 32'd5, 4'hF);
    wr(A_CMP1H, 32'd0, 4'hF);
    chk("tirq_pre", 64'(timer_irq), 64'd0);
    timer_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tirq_step%0d", k), 64'(timer_irq), (k >= 6) ? 64'd2 : 64'd0);
    end
    timer_en = 1'b0;
    wr(A_CMP1H, 32'd1, 4'hF);
    chk("tirq_fall_lat", 64'(timer_irq), 64'd2);
    @(posedge clk); #1;
    chk("tirq_fall", 64'(timer_irq), 64'd0);

    // MSIP with byte strobes
    wr(A_MSIP1, 32'h0001_0001, 4'b0001);
    chk("msip1_sw", 64'(sw_irq), 64'd2);
    chk("msip1_ex", 64'(ex_irq), 64'd0);
    wr(A_MSIP0, 32'h0001_0000, 4'b0100);
    chk("msip0_ex", 64'(ex_irq), 64'd1);
    chk("msip0_sw", 64'(sw_irq), 64'd2);
    rd(A_MSIP0, 32'h0001_0000, "msip0_rd");
    rd(A_MSIP1, 32'h0000_0001, "msip1_rd");
    wr(A_CMP0L, 32'hAABB_CCDD, 4'b0011);
    rd(A_CMP0L, 32'hFFFF_CCDD, "cmp0_strb");

    // Write colliding with a tick, unmapped reads
    timer_en = 1'b1;
    wr(A_MLO, 32'h10, 4'hF);
    timer_en = 1'b0;
    rd(A_MLO, 32'h10, "tick_wr_lo");
    rd(A_MHI, 32'h0, "tick_wr_hi");
    rd(A_HOLE, 32'h0, "hole_rd");
    rd(A_MSIP2, 32'h0, "hart2_rd");

    // Reset while a read response is in flight
    rready = 1'b1; raddr = A_MLO;
    @(posedge clk); #1;
    rready = 1'b0;
    resetb = 1'b0;
    #1;
    chk("midrst_rresp", 64'(rresp), 64'd0);
    chk("midrst_rdata", 64'(rdata), 64'd0);
    chk("midrst_sw", 64'(sw_irq), 64'd0);
    chk("midrst_ex", 64'(ex_irq), 64'd0);
    @(posedge clk); #1;
    resetb = 1'b1;
    rd(A_MLO, 32'd0, "post_rst_mtime");
    rd(A_CMP1L, 32'hFFFF_FFFF, "post_rst_cmp1");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
